// File: rtl/vga_grid_arbiter.sv
// vga_grid_arbiter: shares the board RAM between VGA pixel fetch and the game.
// Optional macro BLANK_ONLY_WRITE_EN: game writes wait for display_area=0.
module vga_grid_arbiter #(
    parameter int PIXEL_DISPLAY_BIT = 9,
    parameter int CELL_SHIFT        = 4,
    parameter int GRID_W            = 40,
    parameter int ADDR_W            = 11
) (
    input  logic                       clock_25,
    input  logic                       reset,
    input  logic [PIXEL_DISPLAY_BIT:0] X,
    input  logic [PIXEL_DISPLAY_BIT:0] Y,
    input  logic                       display_area,
    input  logic                       h_sync_in,
    input  logic                       v_sync_in,
    output logic                       display_area_q,
    output logic                       h_sync_q,
    output logic                       v_sync_q,
    output logic [1:0]                 game_data,
    output logic                       frame_tick,
    input  logic                       game_req,
    input  logic                       game_we,
    input  logic [ADDR_W-1:0]          game_addr,
    input  logic [1:0]                 game_wdata,
    output logic                       game_ack,
    output logic [1:0]                 game_rdata,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_we,
    output logic [1:0]                 mem_wdata,
    input  logic [1:0]                 mem_rdata
);

    localparam int PW = PIXEL_DISPLAY_BIT + 1;
    localparam logic [PW-1:0] LAST_ROW = PW'(479);

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_RD   = 2'd1,
        G_ACK  = 2'd2
    } g_state_t;

    g_state_t state;
    g_state_t state_nxt;

    logic              vga_slot;
    logic              slot_q;
    logic              wr_ok;
    logic              issue;
    logic [ADDR_W-1:0] cell_row;
    logic [ADDR_W-1:0] cell_col;
    logic [ADDR_W-1:0] vga_addr;
    logic              da_d1;
    logic              hs_d1;
    logic              vs_d1;

    // Slot detection and pixel-to-cell address translation
    always_comb begin
        vga_slot = display_area && (X[CELL_SHIFT-1:0] == '0);
        cell_row = ADDR_W'(Y >> CELL_SHIFT);
        cell_col = ADDR_W'(X >> CELL_SHIFT);
        vga_addr = cell_row * ADDR_W'(GRID_W) + cell_col;
`ifdef BLANK_ONLY_WRITE_EN
        wr_ok = !display_area;
`else
        wr_ok = 1'b1;
`endif
        issue = game_req && !vga_slot && (!game_we || wr_ok);
    end

    // Game FSM next state and RAM port mux; VGA slot has priority
    always_comb begin
        state_nxt = state;
        game_ack  = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (vga_slot) begin
            mem_addr = vga_addr;
        end
        unique case (state)
            G_IDLE: begin
                if (issue) begin
                    mem_addr  = game_addr;
                    mem_we    = game_we;
                    mem_wdata = game_we ? game_wdata : 2'b00;
                    state_nxt = game_we ? G_ACK : G_RD;
                end
            end
            G_RD: begin
                state_nxt = G_ACK;
            end
            G_ACK: begin
                game_ack  = 1'b1;
                state_nxt = G_IDLE;
                if (issue) begin
                    mem_addr  = game_addr;
                    mem_we    = game_we;
                    mem_wdata = game_we ? game_wdata : 2'b00;
                    state_nxt = game_we ? G_ACK : G_RD;
                end
            end
            default: begin
                state_nxt = G_IDLE;
            end
        endcase
        if (reset) begin
            game_ack  = 1'b0;
            mem_addr  = '0;
            mem_we    = 1'b0;
            mem_wdata = '0;
        end
    end

    // End of the last visible line marks the start of vertical blanking
    always_comb begin
        frame_tick = da_d1 && !display_area && (Y == LAST_ROW) && !reset;
    end

    // Game FSM state register
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            state <= G_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Two-stage sync pipeline keeps syncs aligned with game_data
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            da_d1          <= 1'b0;
            hs_d1          <= 1'b0;
            vs_d1          <= 1'b0;
            display_area_q <= 1'b0;
            h_sync_q       <= 1'b0;
            v_sync_q       <= 1'b0;
        end else begin
            da_d1          <= display_area;
            hs_d1          <= h_sync_in;
            vs_d1          <= v_sync_in;
            display_area_q <= da_d1;
            h_sync_q       <= hs_d1;
            v_sync_q       <= vs_d1;
        end
    end

    // Capture RAM data for the VGA slot issued last cycle
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            slot_q    <= 1'b0;
            game_data <= 2'b00;
        end else begin
            slot_q <= vga_slot;
            if (slot_q) begin
                game_data <= mem_rdata;
            end
        end
    end

    // Capture game read data in G_RD; held until the next read
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            game_rdata <= 2'b00;
        end else if (state == G_RD) begin
            game_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_vga_grid_arbiter.sv
// tb_vga_grid_arbiter: directed bench for vga_grid_arbiter.
// Models a 1-cycle synchronous RAM; optional macro BLANK_ONLY_WRITE_EN.
module tb_vga_grid_arbiter;

    logic        clock_25;
    logic        reset;
    logic [9:0]  X;
    logic [9:0]  Y;
    logic        display_area;
    logic        h_sync_in;
    logic        v_sync_in;
    logic        display_area_q;
    logic        h_sync_q;
    logic        v_sync_q;
    logic [1:0]  game_data;
    logic        frame_tick;
    logic        game_req;
    logic        game_we;
    logic [10:0] game_addr;
    logic [1:0]  game_wdata;
    logic        game_ack;
    logic [1:0]  game_rdata;
    logic [10:0] mem_addr;
    logic        mem_we;
    logic [1:0]  mem_wdata;
    logic [1:0]  mem_rdata;

    logic [1:0]  ram [0:2047];
    int          checks;
    int          errors;
    int          ticks;

    vga_grid_arbiter dut (
        .clock_25      (clock_25),
        .reset         (reset),
        .X             (X),
        .Y             (Y),
        .display_area  (display_area),
        .h_sync_in     (h_sync_in),
        .v_sync_in     (v_sync_in),
        .display_area_q(display_area_q),
        .h_sync_q      (h_sync_q),
        .v_sync_q      (v_sync_q),
        .game_data     (game_data),
        .frame_tick    (frame_tick),
        .game_req      (game_req),
        .game_we       (game_we),
        .game_addr     (game_addr),
        .game_wdata    (game_wdata),
        .game_ack      (game_ack),
        .game_rdata    (game_rdata),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    initial clock_25 = 1'b0;
    always #5 clock_25 = ~clock_25;

    always @(posedge clock_25) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clock_25);
        #1;
    endtask

    task automatic settle();
        @(negedge clock_25);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ticks = 0;
        for (int i = 0; i < 2048; i++) ram[i] = 2'b00;
        ram[40] = 2'b10;
        ram[1199] = 2'b11;
        mem_rdata = 2'b00;
        reset = 1'b1;
        X = '0;
        Y = '0;
        display_area = 1'b0;
        h_sync_in = 1'b0;
        v_sync_in = 1'b0;
        game_req = 1'b0;
        game_we = 1'b0;
        game_addr = '0;
        game_wdata = '0;

        // reset state
        next(); next(); settle();
        chk("rst_mem_addr", 16'(mem_addr), 16'd0);
        chk("rst_mem_we", 16'(mem_we), 16'd0);
        chk("rst_game_data", 16'(game_data), 16'd0);
        chk("rst_ack", 16'(game_ack), 16'd0);
        chk("rst_daq", 16'(display_area_q), 16'd0);
        chk("rst_tick", 16'(frame_tick), 16'd0);
        next(); reset = 1'b0; settle();

        // pixel fetch X=0 Y=16
        next(); X = 10'd0; Y = 10'd16; display_area = 1'b1; settle();
        chk("fetch_addr", 16'(mem_addr), 16'd40);
        chk("fetch_we", 16'(mem_we), 16'd0);
        for (int x = 1; x <= 18; x++) begin
            next(); X = 10'(x); settle();
            if (x == 1) chk("daq_early", 16'(display_area_q), 16'd0);
            if (x == 2) chk("daq_rise", 16'(display_area_q), 16'd1);
            if (x >= 2 && x <= 17) chk("fetch_data", 16'(game_data), 16'd2);
            if (x == 16) chk("fetch_addr2", 16'(mem_addr), 16'd41);
            if (x == 18) chk("fetch_data2", 16'(game_data), 16'd0);
        end

`ifdef BLANK_ONLY_WRITE_EN
        // write during visible region waits for blanking
        next(); X = 10'd100; game_req = 1'b1; game_we = 1'b1;
        game_addr = 11'd5; game_wdata = 2'b01; settle();
        chk("bw_we_vis", 16'(mem_we), 16'd0);
        for (int x = 101; x <= 103; x++) begin
            next(); X = 10'(x); settle();
            chk("bw_we_hold", 16'(mem_we), 16'd0);
            chk("bw_ack_hold", 16'(game_ack), 16'd0);
        end
        next(); X = 10'd640; display_area = 1'b0; settle();
        chk("bw_we", 16'(mem_we), 16'd1);
        chk("bw_addr", 16'(mem_addr), 16'd5);
        next(); X = 10'd641; game_req = 1'b0; settle();
        chk("bw_ack", 16'(game_ack), 16'd1);
`else
        // write collides with VGA slot at X=32
        next(); X = 10'd32; game_req = 1'b1; game_we = 1'b1;
        game_addr = 11'd5; game_wdata = 2'b01; settle();
        chk("col_vga_addr", 16'(mem_addr), 16'd42);
        chk("col_vga_we", 16'(mem_we), 16'd0);
        chk("col_ack0", 16'(game_ack), 16'd0);
        next(); X = 10'd33; settle();
        chk("col_we", 16'(mem_we), 16'd1);
        chk("col_addr", 16'(mem_addr), 16'd5);
        chk("col_wdata", 16'(mem_wdata), 16'd1);
        chk("col_ack1", 16'(game_ack), 16'd0);
        next(); X = 10'd34; game_req = 1'b0; settle();
        chk("col_ack", 16'(game_ack), 16'd1);
        chk("col_we_off", 16'(mem_we), 16'd0);
        next(); X = 10'd35; settle();
        chk("col_ack_end", 16'(game_ack), 16'd0);
`endif

        // blanking read of 1199 plus sync pipeline
        next(); display_area = 1'b0; X = 10'd700; Y = 10'd500;
        game_req = 1'b1; game_we = 1'b0; game_addr = 11'd1199;
        h_sync_in = 1'b1; v_sync_in = 1'b1; settle();
        chk("rd_addr", 16'(mem_addr), 16'd1199);
        chk("rd_we", 16'(mem_we), 16'd0);
        chk("hs_d0", 16'(h_sync_q), 16'd0);
        next(); h_sync_in = 1'b0; v_sync_in = 1'b0; settle();
        chk("rd_ack0", 16'(game_ack), 16'd0);
        chk("hs_d1", 16'(h_sync_q), 16'd0);
        next(); game_req = 1'b0; settle();
        chk("rd_ack", 16'(game_ack), 16'd1);
        chk("rd_data", 16'(game_rdata), 16'd3);
        chk("hs_d2", 16'(h_sync_q), 16'd1);
        chk("vs_d2", 16'(v_sync_q), 16'd1);
        chk("rd_vga_quiet", 16'(game_data), 16'd0);
        next(); settle();
        chk("rd_ack_end", 16'(game_ack), 16'd0);
        chk("rd_hold", 16'(game_rdata), 16'd3);
        chk("hs_d3", 16'(h_sync_q), 16'd0);

        // read back the written cell
        next(); game_req = 1'b1; game_addr = 11'd5; settle();
        next(); settle();
        next(); game_req = 1'b0; settle();
        chk("rb_ack", 16'(game_ack), 16'd1);
        chk("rb_data", 16'(game_rdata), 16'd1);

        // read colliding with VGA slot: worst-case latency
        next(); Y = 10'd16; X = 10'd48; display_area = 1'b1;
        game_req = 1'b1; game_addr = 11'd1199; settle();
        chk("wc_vga_addr", 16'(mem_addr), 16'd43);
        chk("wc_ack0", 16'(game_ack), 16'd0);
        next(); X = 10'd49; settle();
        chk("wc_addr", 16'(mem_addr), 16'd1199);
        next(); X = 10'd50; settle();
        chk("wc_ack2", 16'(game_ack), 16'd0);
        next(); X = 10'd51; game_req = 1'b0; settle();
        chk("wc_ack", 16'(game_ack), 16'd1);
        chk("wc_data", 16'(game_rdata), 16'd3);

        // no tick at end of line 478
        next(); Y = 10'd478; X = 10'd639; display_area = 1'b1; settle();
        next(); X = 10'd640; display_area = 1'b0; settle();
        chk("tick_478", 16'(frame_tick), 16'd0);

        // one tick at end of line 479
        next(); Y = 10'd479; settle();
        for (int x = 636; x <= 643; x++) begin
            next(); X = 10'(x); display_area = (x < 640); settle();
            if (frame_tick) ticks++;
            if (x == 640) chk("tick_479", 16'(frame_tick), 16'd1);
        end
        chk("tick_count", 16'(ticks), 16'd1);

        // reset during G_RD
        next(); Y = 10'd16; X = 10'd0; display_area = 1'b1; settle();
        next(); X = 10'd1; settle();
        next(); X = 10'd2; settle();
        chk("pre_rst_data", 16'(game_data), 16'd2);
        next(); display_area = 1'b0; X = 10'd700; Y = 10'd500;
        game_req = 1'b1; game_we = 1'b0; game_addr = 11'd1199; settle();
        chk("pre_rst_addr", 16'(mem_addr), 16'd1199);
        next(); reset = 1'b1; game_req = 1'b0; settle();
        chk("mid_rst_ack", 16'(game_ack), 16'd0);
        chk("mid_rst_addr", 16'(mem_addr), 16'd0);
        chk("mid_rst_rdata", 16'(game_rdata), 16'd0);
        chk("mid_rst_data", 16'(game_data), 16'd0);
        chk("mid_rst_daq", 16'(display_area_q), 16'd0);
        next(); reset = 1'b0; settle();
        chk("post_rst_ack1", 16'(game_ack), 16'd0);
        next(); settle();
        chk("post_rst_ack2", 16'(game_ack), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
